// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - bf8b instruction fetch: arbiter read client, pc walker, tagged prefetch FIFO
// Optional build macro: FETCH_SKIP_NOP_EN (drop non-command bytes instead of pushing them)

module fetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata,
    output logic       ins_valid,
    output logic [7:0] ins,
    output logic [7:0] ins_addr,
    input  logic       ins_ready,
    input  logic       jump,
    input  logic [7:0] jump_addr,
    output logic       halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        pc_q, pc_d;
    logic [7:0]        addr_q, addr_d;
    logic              discard_q, discard_d;
    logic [15:0]       fifo_q [DEPTH];
    logic [15:0]       fifo_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              keep_byte;
    logic              push;
    logic              pop;

`ifdef FETCH_SKIP_NOP_EN
    function automatic logic is_cmd(input logic [7:0] b);
        case (b)
            8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C, 8'h00: is_cmd = 1'b1;
            default: is_cmd = 1'b0;
        endcase
    endfunction

    // Comment text is consumed (pc advances) but never reaches exec
    always_comb begin
        keep_byte = is_cmd(mem_rdata);
    end
`else
    // Every nonzero byte is an instruction candidate
    always_comb begin
        keep_byte = 1'b1;
    end
`endif

    // Fixed read-only port and registered outputs
    assign mem_we    = 1'b0;
    assign mem_wdata = 8'h00;
    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = addr_q;
    assign halted    = (state_q == S_HALT);
    assign ins_valid = (count_q != '0);
    assign ins       = fifo_q[rd_ptr_q][15:8];
    assign ins_addr  = fifo_q[rd_ptr_q][7:0];

    // Request FSM: one outstanding read, grant must drop before the next request
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A jump in IDLE only retargets pc; the request goes out next cycle from the new pc
                if (jump) begin
                    pc_d = jump_addr;
                end else if ((count_q < FULL_CNT) && !mem_ready) begin
                    state_d = S_REQ;
                    addr_d  = pc_q;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d   = S_RELEASE;
                    discard_d = 1'b0;
                    if (jump) begin
                        pc_d = jump_addr;
                    end else if (!discard_q) begin
                        pc_d = pc_q + 8'd1;
                        if (mem_rdata == 8'h00) begin
                            state_d = S_HALT;
                        end else begin
                            push = keep_byte;
                        end
                    end
                end else if (jump) begin
                    // Grant cannot be aborted: let it finish, then throw the byte away
                    pc_d      = jump_addr;
                    discard_d = 1'b1;
                end
            end
            S_RELEASE: begin
                if (jump) begin
                    pc_d = jump_addr;
                end
                if (!mem_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                if (jump) begin
                    pc_d    = jump_addr;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Prefetch FIFO: jump flushes and overrides any same-cycle pop
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = ins_valid && ins_ready;
        if (jump) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = {mem_rdata, addr_q};
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State and storage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= 8'h00;
            addr_q    <= 8'h00;
            discard_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= 16'h0000;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fifo_q    <= fifo_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch client of the shared memory arbiter for the bf8b core.
- Issues read-only requests on its arbiter port and walks the program counter.
- Buffers fetched opcode bytes, each tagged with its address, in a small prefetch FIFO.
- Presents the buffered bytes to the exec stage through a valid/ready handshake. Exec redirects fetch through a jump port on loop branches.

## Interface
Parameters:
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  request to arbiter; held until mem_ready is sampled high.
- mem_addr  out  8  read address; equals pc while mem_req is high.
- mem_we  out  1  constant 0.
- mem_wdata  out  8  constant 0x00.
- mem_ready  in  1  arbiter grant-complete; mem_rdata is valid in any cycle it is high.
- mem_rdata  in  8  memory read data.
- ins_valid  out  1  FIFO head valid.
- ins  out  8  opcode at FIFO head.
- ins_addr  out  8  address of the opcode at FIFO head.
- ins_ready  in  1  exec accepts the head this cycle.
- jump  in  1  one-cycle redirect pulse from exec.
- jump_addr  in  8  new pc; sampled when jump is high.
- halted  out  1  terminator byte 0x00 fetched; fetching stopped.

## Operation
- State machine:
  - IDLE: if not halted, FIFO count < DEPTH and mem_ready is low, go to REQ with mem_req=1 and mem_addr=pc.
  - REQ: hold mem_req and mem_addr stable. When mem_ready is sampled high:
    - capture mem_rdata;
    - set mem_req to 0;
    - set pc to pc+1 (mod 256, so 0xFF wraps to 0x00);
    - go to RELEASE.
  - RELEASE: wait for mem_ready to be sampled low, then go to IDLE. Stale ready must never be taken as a new grant.
  - HALT: entered when a captured byte is 0x00. That byte is not pushed. halted=1. No requests are issued.
- Captured nonzero byte: push {mem_rdata, address} into the FIFO.
- Pop happens when ins_valid && ins_ready.
- Push and pop in the same cycle leave the count unchanged.
- A push never occurs when the FIFO is full, because a request is only issued when count < DEPTH.
- jump:
  - Clears the FIFO (count=0), sets pc to jump_addr, clears halted, and leaves HALT for IDLE.
  - If jump arrives in REQ, mem_req stays high until mem_ready. The returned byte is discarded without a push or a HALT check. pc is not incremented, so it keeps jump_addr. The FSM then goes to RELEASE. The arbiter cannot abort a grant.
  - If jump coincides with a capture, the jump wins and the byte is discarded.
  - If jump coincides with a pop, the FIFO is cleared and the pop is ignored.
- Reset (asynchronous, mid-operation included): all outputs return to reset values and any outstanding request is abandoned.

## Timing
- Reset values:
  - mem_req=0, mem_addr=0x00, mem_we=0, mem_wdata=0x00.
  - ins_valid=0, ins=0x00, ins_addr=0x00, halted=0.
  - pc=0x00, FIFO empty, state IDLE.
- mem_req rises on the first rising clk edge after rst deasserts, provided mem_ready is low.
- mem_req falls on the same edge that samples mem_ready=1.
- The captured byte's ins_valid is high in the cycle after that edge, if the FIFO was empty.
- The next request rises no earlier than the edge after mem_ready is sampled low.
- At most one request is ever outstanding.
- ins, ins_addr and ins_valid come directly from FIFO registers. There is no combinational path from ins_ready.
- halted rises on the edge that captures 0x00 and falls on the edge that samples jump=1.

## Configuration
- FETCH_SKIP_NOP_EN defined: a captured byte outside {0x2B, 0x2D, 0x3C, 0x3E, 0x5B, 0x5D, 0x2E, 0x2C, 0x00} is dropped. pc still advances and the FSM still goes through RELEASE, so comment text is never presented to exec.
- FETCH_SKIP_NOP_EN undefined: every nonzero byte is pushed.

## Test plan
- Reset, then bench memory holding "+-" followed by 0x00, with the bench arbiter model answering requests:
  - exec pops {0x2B, 0x00} then {0x2D, 0x01};
  - halted=1 after the fetch at address 0x02;
  - mem_req stays 0 afterwards.
- ins_ready held 0, DEPTH=4, memory full of 0x3E:
  - exactly 4 requests are issued, for addresses 0x00 to 0x03;
  - ins_valid=1 with head {0x3E, 0x00};
  - no 5th request until one pop.
- Jump to 0x10 issued while in REQ for address 0x05:
  - the byte from 0x05 is discarded;
  - the FIFO is empty;
  - the next request addresses 0x10;
  - the first popped entry is {mem[0x10], 0x10}.
- pc=0xFF, memory[0xFF]=0x2E, memory[0x00]=0x2C:
  - pops are {0x2E, 0xFF} then {0x2C, 0x00}.
- rst pulled low while mem_req=1:
  - mem_req, ins_valid and halted are 0 immediately;
  - after release, the first request addresses 0x00.
- With FETCH_SKIP_NOP_EN, memory "a+b" followed by 0x00:
  - the only pop is {0x2B, 0x01};
  - halted=1.
  - Without the macro, the pops are {0x61, 0x00}, {0x2B, 0x01}, {0x62, 0x02}.
